// File: rtl/s2p_pkg.sv
// s2p_pkg: shared types and helpers for the s2p_rx serial receiver.
// Holds the FSM encoding and the counter width function.
package s2p_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/s2p_rx_sync_edge.sv
// sync_edge: N-stage synchronizer with registered rise/fall pulses.
// q is the history flop, so it lines up with the edge pulses.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sh;
    logic              hist;

    // synchronizer chain, history flop and registered edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= {STAGES{RST_VAL}};
            hist <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sh   <= {sh[STAGES-2:0], d};
            hist <= sh[STAGES-1];
            rise <= sh[STAGES-1] & ~hist;
            fall <= ~sh[STAGES-1] & hist;
        end
    end

    assign q = hist;

endmodule

// File: rtl/s2p_rx.sv
// s2p_rx: oversampling serial-to-parallel receiver for sclk/sclr/sin/sen.
// Shifts MSB first while sen is low and latches the word on sen rise.
module s2p_rx #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             sclr,
    input  logic             sin,
    input  logic             sen,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);
    import s2p_pkg::*;

    localparam int CW = clog2(WIDTH + 2);

    logic sclk_s, sclk_rise, sclk_fall;
    logic sen_s, sen_rise, sen_fall;
    logic sclr_s, sclr_rise, sclr_fall;
    logic sin_s;
    logic sclk_unused;
    logic sclr_unused;

    logic [SYNC_STAGES:0] sin_sh;
    logic [SYNC_STAGES:0] warm;
    logic                 armed;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             latch;
    logic             good;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sen (
        .clk(clk), .rst_n(rst_n), .d(sen),
        .q(sen_s), .rise(sen_rise), .fall(sen_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclr (
        .clk(clk), .rst_n(rst_n), .d(sclr),
        .q(sclr_s), .rise(sclr_rise), .fall(sclr_fall)
    );

    assign sclk_unused = sclk_s ^ sclk_fall;
    assign sclr_unused = sclr_rise ^ sclr_fall;

    // sin gets the same depth as the edge path so it stays aligned with sclk_s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sin_sh <= '0;
        else        sin_sh <= {sin_sh[SYNC_STAGES-1:0], sin};
    end

    assign sin_s = sin_sh[SYNC_STAGES];

    // ignore the fake sen fall when the pin was already low at reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            warm  <= {warm[SYNC_STAGES-1:0], 1'b1};
            armed <= armed | (warm[SYNC_STAGES] & sen_s);
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state, shift register, counter and latch decision
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        good    = 1'b0;
        if (sen_rise && state_q != IDLE) begin
            latch = 1'b1;
            good  = sclr_s && (cnt_q == CW'(WIDTH));
        end
        if (!sclr_s) begin
            sr_d    = '0;
            cnt_d   = '0;
            state_d = sen_s ? IDLE : SHIFT;
        end else if (sen_rise) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sen_fall && armed) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        sr_d  = {sr_q[WIDTH-2:0], sin_s};
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH)) state_d = OVER;
                    end
                end
                OVER: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // datapath registers and output word / flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            valid <= latch & good;
            if (latch) begin
                frame_err <= ~good;
                if (good) data <= sr_q;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_s2p_rx.sv
// tb_s2p_rx: scoreboard bench for s2p_rx.
// Driver queues expected words; a monitor checks them on valid.
module tb_s2p_rx;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sclk;
    logic         sclr;
    logic         sin;
    logic         sen;
    logic [W-1:0] data;
    logic         valid;
    logic         frame_err;
    logic         busy;

    s2p_rx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sclr(sclr),
        .sin(sin), .sen(sen), .data(data), .valid(valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] word;
        int           at;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   nvec = 0;
    int   nbad = 0;
    logic prev_v = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nbad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (prev_v) begin
                nvec++;
                nbad++;
                $display("FAIL valid_width: valid high 2 cycles, want 1");
            end
            if (expq.size() == 0) begin
                nvec++;
                nbad++;
                $display("FAIL unexpected_valid: data %0h, want no valid", data);
            end else begin
                mon_e = expq.pop_front();
                chk("word", 32'(data), 32'(mon_e.word));
                chk("valid_cycle", 32'(cyc), 32'(mon_e.at));
                chk("err_at_valid", 32'(frame_err), 32'd0);
            end
        end
        prev_v = valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bitp(input logic b);
        sclk = 1'b0;
        sin  = b;
        tick(4);
        sclk = 1'b1;
        tick(4);
    endtask

    task automatic send(input logic [W-1:0] w, input int n);
        logic [W-1:0] t;
        t = w;
        for (int i = 0; i < n; i++) begin
            bitp(t[W-1]);
            t = t << 1;
        end
    endtask

    task automatic start_f();
        sen = 1'b0;
        tick(4);
    endtask

    task automatic end_f(input logic good, input logic [W-1:0] w);
        exp_t e;
        sen = 1'b1;
        if (good) begin
            e.word = w;
            e.at   = cyc + 4;
            expq.push_back(e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sclk  = 1'b1;
        sclr  = 1'b1;
        sin   = 1'b0;
        sen   = 1'b1;
        tick(3);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(6);

        start_f();
        chk("busy_shift", 32'(busy), 32'd1);
        send(16'hA5C3, 16);
        end_f(1'b1, 16'hA5C3);
        tick(8);
        chk("t1_data", 32'(data), 32'hA5C3);
        chk("t1_err", 32'(frame_err), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        start_f();
        send(16'h1234, 15);
        end_f(1'b0, 16'h0);
        tick(8);
        chk("t2_data", 32'(data), 32'hA5C3);
        chk("t2_err", 32'(frame_err), 32'd1);
        start_f();
        send(16'h0001, 16);
        end_f(1'b1, 16'h0001);
        tick(8);
        chk("t2b_data", 32'(data), 32'h0001);
        chk("t2b_err", 32'(frame_err), 32'd0);

        start_f();
        send(16'hFFFF, 17);
        chk("t3_busy17", 32'(busy), 32'd1);
        bitp(1'b1);
        chk("t3_busy18", 32'(busy), 32'd1);
        end_f(1'b0, 16'h0);
        tick(8);
        chk("t3_err", 32'(frame_err), 32'd1);
        chk("t3_data", 32'(data), 32'h0001);
        chk("t3_busy", 32'(busy), 32'd0);

        start_f();
        send(16'hFFFF, 8);
        sclr = 1'b0;
        tick(3);
        sclr = 1'b1;
        tick(4);
        send(16'h1234, 16);
        end_f(1'b1, 16'h1234);
        tick(8);
        chk("t4_data", 32'(data), 32'h1234);
        chk("t4_err", 32'(frame_err), 32'd0);

        start_f();
        end_f(1'b0, 16'h0);
        tick(8);
        chk("zero_err", 32'(frame_err), 32'd1);
        chk("zero_data", 32'(data), 32'h1234);

        start_f();
        send(16'hFFFF, 9);
        rst_n = 1'b0;
        #1;
        chk("t5_data", 32'(data), 32'd0);
        chk("t5_valid", 32'(valid), 32'd0);
        chk("t5_err", 32'(frame_err), 32'd0);
        tick(1);
        rst_n = 1'b1;
        send(16'hFFFF, 7);
        chk("t5_busy", 32'(busy), 32'd0);
        end_f(1'b0, 16'h0);
        tick(8);
        chk("t5_err_after", 32'(frame_err), 32'd0);
        chk("t5_data_after", 32'(data), 32'd0);

        start_f();
        send(16'hFFFF, 16);
        end_f(1'b1, 16'hFFFF);
        tick(3);
        sen = 1'b0;
        tick(4);
        send(16'h0000, 16);
        end_f(1'b1, 16'h0000);
        tick(8);
        chk("t6_data", 32'(data), 32'h0000);
        chk("t6_err", 32'(frame_err), 32'd0);

        tick(10);
        chk("queue_empty", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
